// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the core memory stage and a big-endian, byte-addressed data memory.
// Sub-word stores are done as read-modify-write; loads are sign- or zero-extended from the top bytes of mem_rd.
module dmem_lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        mem_rdy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [CW-1:0] tcnt;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        illegal;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign mem_ren   = (state == RD);
  assign mem_wen   = (state == WR);

  // The end address is formed in 33 bits so an address near 2^32 cannot wrap into range.
  always_comb begin
    nbytes = 3'd4;
    case (req_funct3[1:0])
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr = {1'b0, req_addr} + 33'(nbytes);
    illegal  = (end_addr > 33'(MEM_BYTES))
             || (req_funct3 == 3'd3)
             || (req_funct3[2:1] == 2'b11)
             || (req_we && req_funct3[2]);
  end

  always_comb begin
    load_val = mem_rd;
    case (f3_q)
      3'd0:    load_val = {{24{mem_rd[31]}}, mem_rd[31:24]};
      3'd1:    load_val = {{16{mem_rd[31]}}, mem_rd[31:16]};
      3'd4:    load_val = {24'd0, mem_rd[31:24]};
      3'd5:    load_val = {16'd0, mem_rd[31:16]};
      default: load_val = mem_rd;
    endcase
    merged = f3_q[0] ? {mem_wd[15:0], mem_rd[15:0]} : {mem_wd[7:0], mem_rd[23:0]};
  end

  // Store data parks in mem_wd from accept, so the merge step reads its low bytes from there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      tcnt     <= '0;
      mem_addr <= 32'd0;
      mem_wd   <= 32'd0;
      rdata    <= 32'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            mem_addr <= req_addr;
            tcnt     <= '0;
            if (req_we) mem_wd <= req_wdata;
            if (illegal) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (req_we && (req_funct3[1:0] == 2'd2)) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (mem_rdy) begin
            if (we_q) begin
              mem_wd <= merged;
              state  <= WR;
            end else begin
              rdata <= load_val;
              state <= DONE;
            end
          end else if (tcnt == CW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WR: state <= DONE;
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: byte-array memory responder, fixed vector table, hand sequences
// and random accesses checked against a byte-level reference model.
module tb_dmem_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_rdy;
  logic        rdy_en;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [7:0]  ref_mem [256];
  logic [31:0] ref_rdata;

  dmem_lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .rdata(rdata), .err(err), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_rdy(mem_rdy)
  );

  // Memory responder: big-endian word at mem_addr, bytes past the end read as zero.
  always_comb begin
    mem_rd = 32'd0;
    for (int i = 0; i < 4; i++)
      if (({1'b0, mem_addr} + 33'(i)) < 33'd256)
        mem_rd[31-8*i -: 8] = mem[mem_addr[7:0] + 8'(i)];
  end
  assign mem_rdy = mem_ren & rdy_en;

  always @(posedge clk)
    if (mem_wen)
      for (int i = 0; i < 4; i++)
        if (({1'b0, mem_addr} + 33'(i)) < 33'd256)
          mem[mem_addr[7:0] + 8'(i)] <= mem_wd[31-8*i -: 8];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        exp_err;
    int          exp_lat;
    int          exp_ren;
    int          exp_wen;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: works on the byte array with plain arithmetic, one whole access at a time.
  task automatic modelOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rdy,
                         output logic e_err, output int e_lat, output int e_ren, output int e_wen,
                         output logic [31:0] e_wd, output logic [31:0] e_rdata);
    int     nb;
    longint end_a;
    longint v;
    bit     bad_acc;
    nb      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    end_a   = {32'h0, addr};
    end_a   = end_a + nb;
    bad_acc = (end_a > 256) || (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4);
    e_err = 1'b0; e_lat = 0; e_ren = 0; e_wen = 0; e_wd = 32'd0;
    if (bad_acc) begin
      e_err = 1'b1; e_lat = 1;
    end else if (!rdy && !(we && nb == 4)) begin
      e_err = 1'b1; e_lat = 9; e_ren = 8;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v * 256 + ref_mem[int'(addr) + i];
      if (!f3[2] && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
      ref_rdata = 32'(v);
      e_lat = 2; e_ren = 1;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8*(nb - 1 - i)));
      for (int i = 0; i < 4; i++)
        e_wd = (e_wd << 8) | ((int'(addr) + i < 256) ? 32'(ref_mem[int'(addr) + i]) : 32'd0);
      e_lat = (nb == 4) ? 2 : 3;
      e_ren = (nb == 4) ? 0 : 1;
      e_wen = 1;
    end
    e_rdata = ref_rdata;
  endtask

  // Issues one access from a negedge and watches it until done, counting strobes.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic rdy,
                               output int lat, output int ren_n, output int wen_n,
                               output logic [31:0] wd_seen, output bit addr_ok,
                               output logic err_seen, output logic [31:0] rdata_seen);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    req = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; rdy_en = rdy;
    @(negedge clk);
    req = 1'b0;
    lat = 0; ren_n = 0; wen_n = 0; wd_seen = 32'd0; addr_ok = 1'b1;
    err_seen = 1'b0; rdata_seen = 32'd0;
    for (int n = 1; n <= 30; n++) begin
      if (mem_ren) begin ren_n++; if (mem_addr !== addr) addr_ok = 1'b0; end
      if (mem_wen) begin wen_n++; wd_seen = mem_wd; if (mem_addr !== addr) addr_ok = 1'b0; end
      if (done) begin
        lat = n; err_seen = err; rdata_seen = rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic rdy,
                       input logic e_err, input int e_lat, input int e_ren, input int e_wen,
                       input logic [31:0] e_wd, input logic [31:0] e_rdata);
    int          lat, ren_n, wen_n;
    logic [31:0] wd_seen, rd_seen;
    logic        err_seen;
    bit          addr_ok;
    applyStimulus(we, f3, addr, wdata, rdy, lat, ren_n, wen_n, wd_seen, addr_ok, err_seen, rd_seen);
    checkOutput({tag, " latency"}, 32'(lat), 32'(e_lat));
    checkOutput({tag, " err"}, 32'(err_seen), 32'(e_err));
    checkOutput({tag, " ren cycles"}, 32'(ren_n), 32'(e_ren));
    checkOutput({tag, " wen cycles"}, 32'(wen_n), 32'(e_wen));
    checkOutput({tag, " rdata"}, rd_seen, e_rdata);
    if (e_wen != 0 && wen_n != 0) checkOutput({tag, " mem_wd"}, wd_seen, e_wd);
    if (ren_n + wen_n != 0) checkOutput({tag, " mem_addr"}, 32'(addr_ok), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'd0);
    checkOutput({tag, " mem_ren"}, 32'(mem_ren), 32'd0);
    checkOutput({tag, " mem_wen"}, 32'(mem_wen), 32'd0);
    checkOutput({tag, " rdata"}, rdata, 32'd0);
    checkOutput({tag, " mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, " mem_wd"}, mem_wd, 32'd0);
  endtask

  logic        m_err;
  int          m_lat, m_ren, m_wen;
  logic [31:0] m_wd, m_rdata;

  initial begin
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rdy_en = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_rdata = 32'd0;

    vecs.push_back('{1'b1, 3'd2, 32'h10, 32'h12345678, 1'b1, 1'b0, 2, 0, 1, 32'h12345678, 32'h0});
    vecs.push_back('{1'b1, 3'd0, 32'h11, 32'hCCDDEEAB, 1'b1, 1'b0, 3, 1, 1, 32'hAB567800, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0, 2, 1, 0, 32'h0, 32'h12AB5678});
    vecs.push_back('{1'b0, 3'd0, 32'h11, 32'h0, 1'b1, 1'b0, 2, 1, 0, 32'h0, 32'hFFFFFFAB});
    vecs.push_back('{1'b0, 3'd4, 32'h11, 32'h0, 1'b1, 1'b0, 2, 1, 0, 32'h0, 32'h000000AB});
    vecs.push_back('{1'b0, 3'd1, 32'h10, 32'h0, 1'b1, 1'b0, 2, 1, 0, 32'h0, 32'h000012AB});
    vecs.push_back('{1'b0, 3'd5, 32'h11, 32'h0, 1'b1, 1'b0, 2, 1, 0, 32'h0, 32'h0000AB56});
    vecs.push_back('{1'b0, 3'd2, 32'hFD, 32'h0, 1'b1, 1'b1, 1, 0, 0, 32'h0, 32'h0000AB56});
    vecs.push_back('{1'b1, 3'd4, 32'h20, 32'h77, 1'b1, 1'b1, 1, 0, 0, 32'h0, 32'h0000AB56});
    vecs.push_back('{1'b0, 3'd2, 32'h00, 32'h0, 1'b0, 1'b1, 9, 8, 0, 32'h0, 32'h0000AB56});
    vecs.push_back('{1'b1, 3'd1, 32'h00, 32'h1234, 1'b0, 1'b1, 9, 8, 0, 32'h0, 32'h0000AB56});
    vecs.push_back('{1'b0, 3'd3, 32'h00, 32'h0, 1'b1, 1'b1, 1, 0, 0, 32'h0, 32'h0000AB56});
    vecs.push_back('{1'b0, 3'd1, 32'hFF, 32'h0, 1'b1, 1'b1, 1, 0, 0, 32'h0, 32'h0000AB56});
    vecs.push_back('{1'b0, 3'd0, 32'hFF, 32'h0, 1'b1, 1'b0, 2, 1, 0, 32'h0, 32'h00000000});
    vecs.push_back('{1'b1, 3'd1, 32'h20, 32'h55668001, 1'b1, 1'b0, 3, 1, 1, 32'h80010000, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 32'h20, 32'h0, 1'b1, 1'b0, 2, 1, 0, 32'h0, 32'hFFFF8001});
    vecs.push_back('{1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 1'b1, 1'b1, 1, 0, 0, 32'h0, 32'hFFFF8001});

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      runOp($sformatf("v%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdy,
            vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_ren, vecs[i].exp_wen,
            vecs[i].exp_wd, vecs[i].exp_rdata);
      modelOp(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdy,
              m_err, m_lat, m_ren, m_wen, m_wd, m_rdata);
    end

    // Back-to-back loads with req held high: done pulses land 3 cycles apart.
    begin
      int first_done, second_done, k;
      first_done = 0; second_done = 0; k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      req = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20; rdy_en = 1'b1;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (done) begin
          if (first_done == 0) first_done = n;
          else begin second_done = n; req = 1'b0; break; end
        end
      end
      req = 1'b0;
      modelOp(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, m_err, m_lat, m_ren, m_wen, m_wd, m_rdata);
      modelOp(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, m_err, m_lat, m_ren, m_wen, m_wd, m_rdata);
      checkOutput("b2b first done", 32'(first_done), 32'd2);
      checkOutput("b2b second done", 32'(second_done), 32'd5);
      checkOutput("b2b rdata", rdata, 32'h80010000);
    end

    // Reset in the middle of an SB write phase: strobes drop at once and memory stays untouched.
    begin
      int k;
      bit saw_wen;
      k = 0; saw_wen = 1'b0;
      @(negedge clk);
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      req = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h30; req_wdata = 32'h5A; rdy_en = 1'b1;
      @(negedge clk);
      req = 1'b0;
      for (int n = 1; n <= 10; n++) begin
        if (mem_wen) begin saw_wen = 1'b1; break; end
        @(negedge clk);
      end
      checkOutput("rmw reached wr", 32'(saw_wen), 32'd1);
      #2 rst_n = 1'b0;
      #1 checkResetOutputs("mid-wr reset");
      @(negedge clk);
      rst_n = 1'b1;
      ref_rdata = 32'd0;
      modelOp(1'b0, 3'd4, 32'h30, 32'h0, 1'b1, m_err, m_lat, m_ren, m_wen, m_wd, m_rdata);
      runOp("post-reset lbu", 1'b0, 3'd4, 32'h30, 32'h0, 1'b1, m_err, m_lat, m_ren, m_wen, m_wd, m_rdata);
    end

    for (int i = 0; i < 200; i++) begin
      logic        we, rdy;
      logic [2:0]  f3;
      logic [31:0] addr, wdata;
      int          r;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      else f3 = 3'($urandom_range(0, 7));
      if (!we && f3 == 3'd3 && $urandom_range(0, 1) == 1) f3 = 3'd5;
      r = $urandom_range(0, 9);
      if (r <= 5) addr = 32'($urandom_range(0, 63));
      else if (r <= 7) addr = 32'($urandom_range(248, 263));
      else if (r == 8) addr = 32'($urandom_range(0, 255));
      else addr = $urandom();
      wdata = $urandom();
      rdy = ($urandom_range(0, 9) != 0);
      modelOp(we, f3, addr, wdata, rdy, m_err, m_lat, m_ren, m_wen, m_wd, m_rdata);
      runOp($sformatf("rnd%0d", i), we, f3, addr, wdata, rdy, m_err, m_lat, m_ren, m_wen, m_wd, m_rdata);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
